// File: rtl/accel_throttle_filter_if.sv
// rtl/accel_throttle_filter_if.sv - sample/brake inputs and PWM command outputs of the throttle filter
interface accel_throttle_filter_if #(
    parameter int DataWidth = 12
);
    logic                        sampleValid;
    logic signed [DataWidth-1:0] accelData;
    logic                        brake;
    logic [9:0]                  PWMvalue;
    logic                        filterReady;
    logic                        saturated;

    modport master (
        output sampleValid, accelData, brake,
        input  PWMvalue, filterReady, saturated
    );

    modport slave (
        input  sampleValid, accelData, brake,
        output PWMvalue, filterReady, saturated
    );
endinterface

// File: rtl/accel_throttle_filter.sv
// rtl/accel_throttle_filter.sv - moving-average, deadband and slew-limited PWM duty command
module accel_throttle_filter #(
    parameter int DataWidth    = 12,
    parameter int AvgLog2      = 3,
    parameter int Deadband     = 40,
    parameter int RampDiv      = 50000,
    parameter int RampUpStep   = 4,
    parameter int RampDownStep = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    accel_throttle_filter_if.slave   bus
);
    localparam int MagW  = DataWidth - 1;
    localparam int Depth = 1 << AvgLog2;
    localparam int SumW  = MagW + AvgLog2;
    localparam int CntW  = (RampDiv > 1) ? $clog2(RampDiv) : 1;

    typedef enum logic {FILL, RUN} state_t;

    state_t              state_q;
    logic [AvgLog2-1:0]  fill_q;
    logic                ready_q;
    logic [MagW-1:0]     buf_q [Depth];
    logic [SumW-1:0]     sum_q;
    logic [AvgLog2-1:0]  wp_q;
    logic [9:0]          target_q;
    logic                sat_q;
    logic [CntW-1:0]     ramp_cnt_q;
    logic [9:0]          pwm_q;
    logic [9:0]          pwm_d;

    logic [MagW-1:0]     sample_mag;
    logic [MagW-1:0]     avg;
    logic [MagW-1:0]     diff;
    logic [9:0]          target_d;
    logic                sat_d;
    logic                tick;
    logic [10:0]         pwm_up;
    logic [10:0]         down_floor;

    // Negative samples count as zero thrust; the sign bit is dropped for non-negative ones
    assign sample_mag = bus.accelData[DataWidth-1] ? '0 : bus.accelData[MagW-1:0];

    // Window fill tracking; the 8th accepted sample enters RUN on the same edge
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= FILL;
            fill_q  <= '0;
            ready_q <= 1'b0;
        end else if (state_q == FILL && bus.sampleValid) begin
            if (fill_q == AvgLog2'(Depth - 1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end else begin
                fill_q <= fill_q + AvgLog2'(1);
            end
        end
    end

    // Circular sample buffer with running sum; oldest entry is replaced in place
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                buf_q[i] <= '0;
            end
            sum_q <= '0;
            wp_q  <= '0;
        end else if (bus.sampleValid) begin
            buf_q[wp_q] <= sample_mag;
            sum_q       <= sum_q - SumW'(buf_q[wp_q]) + SumW'(sample_mag);
            wp_q        <= wp_q + AvgLog2'(1);
        end
    end

    assign avg      = sum_q[SumW-1:AvgLog2];
    assign diff     = (avg > MagW'(Deadband)) ? (avg - MagW'(Deadband)) : '0;
    assign sat_d    = (diff > MagW'(1023));
    assign target_d = sat_d ? 10'd1023 : diff[9:0];

    // Target follows the registered sum one clock later; pinned to zero until the window is full
    always_ff @(posedge CLOCK_50) begin
        if (reset || state_q == FILL) begin
            target_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            sat_q    <= sat_d;
        end
    end

    assign tick = (ramp_cnt_q == CntW'(RampDiv - 1));

    // Free-running ramp divider producing a one-cycle tick every RampDiv clocks
    always_ff @(posedge CLOCK_50) begin
        if (reset || tick) begin
            ramp_cnt_q <= '0;
        end else begin
            ramp_cnt_q <= ramp_cnt_q + CntW'(1);
        end
    end

    assign pwm_up     = {1'b0, pwm_q} + 11'(RampUpStep);
    assign down_floor = {1'b0, target_q} + 11'(RampDownStep);

    // Slew limiter: brake forces zero at once, otherwise step toward target only on tick
    always_comb begin
        pwm_d = pwm_q;
        if (bus.brake) begin
            pwm_d = '0;
        end else if (tick) begin
            if (pwm_q < target_q) begin
                pwm_d = (pwm_up > {1'b0, target_q}) ? target_q : pwm_up[9:0];
            end else if (pwm_q > target_q) begin
                pwm_d = ({1'b0, pwm_q} > down_floor) ? (pwm_q - 10'(RampDownStep)) : target_q;
            end
        end
    end

    // Registered duty command
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign bus.PWMvalue    = pwm_q;
    assign bus.filterReady = ready_q;
    assign bus.saturated   = sat_q;
endmodule

// File: tb/tb_accel_throttle_filter.sv
// tb/tb_accel_throttle_filter.sv - self-checking bench for accel_throttle_filter
module tb_accel_throttle_filter;
    localparam int RD = 10;

    logic CLOCK_50 = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    accel_throttle_filter_if #(.DataWidth(12)) bus ();

    accel_throttle_filter #(
        .DataWidth(12), .AvgLog2(3), .Deadband(40),
        .RampDiv(RD), .RampUpStep(4), .RampDownStep(16)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: window kept as a plain list of the last 8 conditioned samples
    int m_hist[$];
    int m_n, m_cyc, m_tgt, m_sat, m_pwm, m_ready;
    bit m_live = 1'b0;
    bit m_tick;
    int m_s, m_a, m_d, m_nt, m_ns, m_v;

    always @(posedge CLOCK_50) begin
        if (reset) begin
            m_hist.delete();
            m_n = 0; m_cyc = 0; m_tgt = 0; m_sat = 0; m_pwm = 0; m_ready = 0;
            m_live = 1'b1;
        end else begin
            m_tick = ((m_cyc % RD) == RD - 1);
            m_cyc++;
            if (m_n >= 8) begin
                m_s = 0;
                foreach (m_hist[i]) m_s += m_hist[i];
                m_a  = m_s / 8;
                m_d  = (m_a > 40) ? m_a - 40 : 0;
                m_nt = (m_d > 1023) ? 1023 : m_d;
                m_ns = (m_d > 1023) ? 1 : 0;
            end else begin
                m_nt = 0;
                m_ns = 0;
            end
            if (bus.brake) begin
                m_pwm = 0;
            end else if (m_tick) begin
                if (m_pwm < m_tgt)      m_pwm = (m_pwm + 4 > m_tgt) ? m_tgt : m_pwm + 4;
                else if (m_pwm > m_tgt) m_pwm = (m_pwm - 16 < m_tgt) ? m_tgt : m_pwm - 16;
            end
            m_tgt = m_nt;
            m_sat = m_ns;
            if (bus.sampleValid) begin
                m_v = int'(bus.accelData);
                if (m_v < 0) m_v = 0;
                m_hist.push_back(m_v);
                if (m_hist.size() > 8) void'(m_hist.pop_front());
                m_n++;
            end
            m_ready = (m_n >= 8) ? 1 : 0;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge CLOCK_50) begin
        if (m_live) begin
            vectors++;
            if (bus.PWMvalue !== 10'(m_pwm) || bus.filterReady !== 1'(m_ready) ||
                bus.saturated !== 1'(m_sat)) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t pwm=%0d/%0d ready=%0b/%0d sat=%0b/%0d (got/want)",
                         $time, bus.PWMvalue, m_pwm, bus.filterReady, m_ready, bus.saturated, m_sat);
            end
        end
    end

    task automatic check(input string name, input logic [10:0] act, input int exp);
        vectors++;
        if (act !== 11'(exp)) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic send(input int v);
        @(negedge CLOCK_50);
        bus.sampleValid = 1'b1;
        bus.accelData   = 12'(v);
        @(negedge CLOCK_50);
        bus.sampleValid = 1'b0;
    endtask

    task automatic send8(input int v);
        repeat (8) send(v);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic wait_pwm(input int v, input int budget);
        int k;
        k = 0;
        while (m_pwm != v && k < budget) begin
            @(negedge CLOCK_50);
            k++;
        end
        if (m_pwm != v) check("wait_pwm_timeout", 11'(m_pwm), v);
    endtask

    initial begin
        reset           = 1'b1;
        bus.sampleValid = 1'b0;
        bus.accelData   = '0;
        bus.brake       = 1'b0;
        do_reset();
        check("reset_pwm", {1'b0, bus.PWMvalue}, 0);
        check("reset_ready", {10'd0, bus.filterReady}, 0);
        check("reset_sat", {10'd0, bus.saturated}, 0);

        // 8 x 500: ready on the 8th accept, ramp to 460 at 4 per tick
        repeat (7) send(500);
        check("fill_7_not_ready", {10'd0, bus.filterReady}, 0);
        send(500);
        check("fill_8_ready", {10'd0, bus.filterReady}, 1);
        cyc(1200);
        check("ramp_up_460", {1'b0, bus.PWMvalue}, 460);
        cyc(50);
        check("hold_460", {1'b0, bus.PWMvalue}, 460);

        // Negative samples clamp to zero; ramp down by 16 with clamp at 0
        send8(-300);
        cyc(320);
        check("ramp_down_0", {1'b0, bus.PWMvalue}, 0);

        // Saturation at full scale, then inside the deadband
        send8(2047);
        cyc(2);
        check("sat_full", {10'd0, bus.saturated}, 1);
        send8(30);
        cyc(2);
        check("sat_clear", {10'd0, bus.saturated}, 0);

        // Brake from 460 for 3 clocks with a sample accepted meanwhile
        send8(500);
        wait_pwm(460, 1500);
        @(negedge CLOCK_50);
        bus.brake = 1'b1;
        @(negedge CLOCK_50);
        check("brake_zero", {1'b0, bus.PWMvalue}, 0);
        bus.sampleValid = 1'b1;
        bus.accelData   = 12'd2047;
        @(negedge CLOCK_50);
        bus.sampleValid = 1'b0;
        @(negedge CLOCK_50);
        bus.brake = 1'b0;
        check("brake_held", {1'b0, bus.PWMvalue}, 0);
        wait_pwm(4, 30);
        check("brake_restart_4", {1'b0, bus.PWMvalue}, 4);

        // Sample coincident with tick: target 100 -> 200, that tick holds
        do_reset();
        send8(140);
        wait_pwm(100, 400);
        cyc(20);
        begin
            int k;
            k = 0;
            while ((m_cyc % RD) != RD - 1 && k < 2 * RD) begin
                @(negedge CLOCK_50);
                k++;
            end
        end
        bus.sampleValid = 1'b1;
        bus.accelData   = 12'd940;
        @(negedge CLOCK_50);
        bus.sampleValid = 1'b0;
        check("coinc_hold_100", {1'b0, bus.PWMvalue}, 100);
        cyc(RD);
        check("coinc_next_104", {1'b0, bus.PWMvalue}, 104);

        // Reset in RUN at PWM 300, then refill
        send8(800);
        wait_pwm(300, 1500);
        check("pre_reset_300", {1'b0, bus.PWMvalue}, 300);
        do_reset();
        check("midreset_pwm", {1'b0, bus.PWMvalue}, 0);
        check("midreset_ready", {10'd0, bus.filterReady}, 0);
        repeat (7) send(800);
        check("refill_7_ready", {10'd0, bus.filterReady}, 0);
        check("refill_7_pwm", {1'b0, bus.PWMvalue}, 0);
        send(800);
        check("refill_8_ready", {10'd0, bus.filterReady}, 1);
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
